// File: rtl/mul_accum.sv
// mul_accum: dot-product reduction stage fed by the registered multiplier.
// A start pulse (accepted only in IDLE) loads a vector length. The block then
// absorbs exactly that many valid product beats into a signed saturating
// accumulator, and presents the sum on a valid/ready port until it is taken.
//
// Handshake: prod_valid has no backpressure; a beat is consumed on any edge
// where prod_valid=1 in ACCUM, and dropped (prod_drop pulse) otherwise. On the
// output side the sum transfers on the edge where sum_valid & sum_ready are
// both 1; sum_data/sum_ovf hold stable while sum_valid=1 and sum_ready=0.
//
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   start, len       begin a vector of len products (IDLE only)
//   busy             high in ACCUM and DONE
//   prod_valid/data  signed WIDTH-bit product beats
//   prod_drop        1-cycle pulse after a beat arrived outside ACCUM
//   sum_valid/ready  result handshake
//   sum_data         signed ACC_WIDTH-bit saturated sum
//   sum_ovf          saturation happened somewhere in this vector
//   dbg_state        current FSM state (0=IDLE, 1=ACCUM, 2=DONE)
module mul_accum #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 prod_valid,
  input  logic [WIDTH-1:0]     prod_data,
  output logic                 prod_drop,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [ACC_WIDTH-1:0] sum_data,
  output logic                 sum_ovf,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 sum_valid_q, sum_valid_d;
  logic                 prod_drop_q, prod_drop_d;

  // One extra bit of headroom: overflow shows up as the top two bits
  // disagreeing, and the top bit then gives the true sign of the result.
  logic [ACC_WIDTH:0]   add_wide;
  logic [ACC_WIDTH-1:0] add_sat;
  logic                 add_ovf;

  always_comb begin
    add_wide = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-WIDTH){prod_data[WIDTH-1]}}, prod_data};
    add_ovf  = add_wide[ACC_WIDTH] ^ add_wide[ACC_WIDTH-1];
    if (add_ovf) add_sat = add_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else         add_sat = add_wide[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    rem_d       = rem_q;
    prod_drop_d = prod_valid && (state_q != S_ACCUM);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_d = add_sat;
          ovf_d = ovf_q | add_ovf;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // sum_valid_q is always 1 here, so sum_ready alone completes it.
        if (sum_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    sum_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      prod_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
      prod_drop_q <= prod_drop_d;
    end
  end

  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;
  assign sum_data  = acc_q;
  assign sum_ovf   = ovf_q;
  assign prod_drop = prod_drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_accum.sv
// Bench for mul_accum. The accumulator is narrowed to 36 bits here because a
// 40-bit sum of at most 255 32-bit products can never reach the rails.
module tb_mul_accum;

  localparam int W  = 32;
  localparam int AW = 36;
  localparam int CW = 8;
  localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW-1));

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] len;
  logic          busy;
  logic          prod_valid;
  logic [W-1:0]  prod_data;
  logic          prod_drop;
  logic          sum_valid;
  logic          sum_ready;
  logic [AW-1:0] sum_data;
  logic          sum_ovf;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int vec[$];
  logic [AW-1:0] exp_q[$];

  mul_accum #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .busy(busy),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_drop(prod_drop),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_ovf(sum_ovf), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, clamped to the rails after each term.
  task automatic model(output logic [AW-1:0] sum, output logic ovf);
    longint s = 0;
    ovf = 1'b0;
    foreach (vec[i]) begin
      s = s + longint'(vec[i]);
      if (s > ACC_MAX) begin s = ACC_MAX; ovf = 1'b1; end
      if (s < ACC_MIN) begin s = ACC_MIN; ovf = 1'b1; end
    end
    sum = s[AW-1:0];
  endtask

  // driver: start a vector, feed vec with random gaps, hold the result for
  // bp cycles (optionally with stray beats), then take it.
  task automatic run_vector(input string tag, input int gap_max, input int bp, input bit stray);
    logic [AW-1:0] e_sum;
    logic          e_ovf;
    logic [AW-1:0] e;
    model(e_sum, e_ovf);
    exp_q.push_back(e_sum);
    start = 1'b1;
    len   = CW'(vec.size());
    step();
    start = 1'b0;
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    foreach (vec[i]) begin
      prod_valid = 1'b1;
      prod_data  = vec[i];
      step();
      prod_valid = 1'b0;
      prod_data  = W'($urandom);
      chk({tag, "_no_drop"}, 64'(prod_drop), 64'd0);
      if (i != vec.size() - 1) begin
        repeat ($urandom_range(0, gap_max)) begin
          step();
          chk({tag, "_gap_wait"}, 64'(sum_valid), 64'd0);
        end
      end
    end
    e = exp_q.pop_front();
    chk({tag, "_sum_valid"}, 64'(sum_valid), 64'd1);
    chk({tag, "_sum_data"}, 64'(sum_data), 64'(e));
    chk({tag, "_sum_ovf"}, 64'(sum_ovf), 64'(e_ovf));
    for (int k = 0; k < bp; k++) begin
      if (stray) begin
        prod_valid = 1'b1;
        prod_data  = 32'd9;
      end
      step();
      prod_valid = 1'b0;
      chk({tag, "_hold_valid"}, 64'(sum_valid), 64'd1);
      chk({tag, "_hold_data"}, 64'(sum_data), 64'(e));
      chk({tag, "_hold_drop"}, 64'(prod_drop), 64'(stray));
    end
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(sum_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0;
    prod_data = '0; sum_ready = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(sum_valid), 64'd0);
    chk("rst_data", 64'(sum_data), 64'd0);
    chk("rst_ovf", 64'(sum_ovf), 64'd0);
    chk("rst_drop", 64'(prod_drop), 64'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    step();

    // basic dot product
    vec = '{3, -5, 10, 7};
    run_vector("basic", 0, 0, 1'b0);

    // gapped input, backpressure, stray beat during DONE
    vec = '{100, 200, 300};
    start = 1'b1; len = 8'd3; step(); start = 1'b0;
    foreach (vec[i]) begin
      prod_valid = 1'b1; prod_data = vec[i]; step(); prod_valid = 1'b0;
      if (i != 2) repeat (2) step();
    end
    chk("gap_valid", 64'(sum_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin prod_valid = 1'b1; prod_data = 32'd9; end
      step();
      prod_valid = 1'b0;
      chk("gap_hold_data", 64'(sum_data), 64'd600);
      chk("gap_hold_drop", 64'(prod_drop), 64'(k == 2));
    end
    sum_ready = 1'b1; step(); sum_ready = 1'b0;
    chk("gap_idle", 64'(busy), 64'd0);

    // zero length; start ignored in DONE and on the handshake cycle
    start = 1'b1; len = 8'd0; step(); start = 1'b0;
    chk("zero_valid", 64'(sum_valid), 64'd1);
    chk("zero_data", 64'(sum_data), 64'd0);
    chk("zero_ovf", 64'(sum_ovf), 64'd0);
    start = 1'b1; len = 8'd3; step(); start = 1'b0;
    chk("zero_start_ign", 64'(dbg_state), 64'd2);
    sum_ready = 1'b1; start = 1'b1; len = 8'd3; step();
    sum_ready = 1'b0; start = 1'b0;
    chk("hs_start_ign", 64'(busy), 64'd0);
    chk("hs_state", 64'(dbg_state), 64'd0);

    // saturation, coming back off the rail, sticky cleared by a new start
    vec = {};
    repeat (255) vec.push_back(32'h7FFFFFFF);
    run_vector("sat_pos", 0, 1, 1'b0);
    vec = {};
    repeat (20) vec.push_back(32'h7FFFFFFF);
    repeat (3) vec.push_back(32'h80000000);
    run_vector("sat_back", 1, 0, 1'b0);
    vec = {};
    repeat (20) vec.push_back(32'h80000000);
    run_vector("sat_neg", 0, 0, 1'b0);
    vec = '{-1, -1};
    run_vector("sat_clear", 0, 0, 1'b0);

    // reset mid-vector
    start = 1'b1; len = 8'd5; step(); start = 1'b0;
    repeat (2) begin prod_valid = 1'b1; prod_data = 32'd77; step(); end
    prod_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(sum_valid), 64'd0);
    step();
    reset = 1'b0;
    step();
    vec = '{42};
    run_vector("after_rst", 0, 0, 1'b0);

    // drop in IDLE
    prod_valid = 1'b1; prod_data = 32'd55; step(); prod_valid = 1'b0;
    chk("idle_drop", 64'(prod_drop), 64'd1);
    step();
    chk("idle_drop_end", 64'(prod_drop), 64'd0);
    vec = '{8, -2};
    run_vector("post_drop", 0, 0, 1'b0);

    // random vectors
    for (int v = 0; v < 12; v++) begin
      vec = {};
      repeat ($urandom_range(1, 12)) vec.push_back(int'($urandom));
      run_vector("rand", 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
